// File: rtl/vec_magnitude_core.sv
// Euclidean magnitude engine: round(sqrt(x^2+y^2[+z^2])) using a fixed-latency
// restoring bit-serial square root. Valid/ready handshakes on both sides.
module vec_magnitude_core #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    input  logic [W-1:0]   in_z,
    input  logic           in_mode3d,
    input  logic           in_round,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     out_mag,
    output logic [W+1:0]   out_rem,
    output logic           busy
);
    localparam int S  = 2*W + 2;
    localparam int R  = W + 1;
    localparam int Q  = W + 2;
    localparam int CW = $clog2(R + 1);

    localparam logic [S-1:0]  BIT_INIT = {2'b01, {(S-2){1'b0}}};
    localparam logic [CW-1:0] CNT_INIT = CW'(R);

    typedef enum logic [2:0] {IDLE, SQR, SUM, ROOT, RND, OUT} state_t;

    state_t          r_state;
    logic [W-1:0]    r_x, r_y, r_z;
    logic            r_round;
    logic [2*W-1:0]  r_xsq, r_ysq, r_zsq;
    logic [S-1:0]    r_num, r_res, r_bit;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [R-1:0]    r_mag;
    logic [Q-1:0]    r_rem;

    logic [2*W-1:0]  w_xe, w_ye, w_ze;
    logic [S-1:0]    w_sum, w_trial;
    logic            w_ge;

    assign w_xe    = {{W{1'b0}}, r_x};
    assign w_ye    = {{W{1'b0}}, r_y};
    assign w_ze    = {{W{1'b0}}, r_z};
    assign w_sum   = S'(r_xsq) + S'(r_ysq) + S'(r_zsq);
    assign w_trial = r_res + r_bit;
    assign w_ge    = (r_num >= w_trial);

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_mag   = r_mag;
    assign out_rem   = r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_round     <= 1'b0;
            r_xsq       <= '0;
            r_ysq       <= '0;
            r_zsq       <= '0;
            r_num       <= '0;
            r_res       <= '0;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_mag       <= '0;
            r_rem       <= '0;
        end else if (ena) begin
            if (clr) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (in_valid) begin
                        r_x     <= in_x;
                        r_y     <= in_y;
                        r_z     <= in_mode3d ? in_z : '0;
                        r_round <= in_round;
                        r_state <= SQR;
                    end
                    SQR: begin
                        r_xsq   <= w_xe * w_xe;
                        r_ysq   <= w_ye * w_ye;
                        r_zsq   <= w_ze * w_ze;
                        r_state <= SUM;
                    end
                    SUM: begin
                        r_num   <= w_sum;
                        r_res   <= '0;
                        r_bit   <= BIT_INIT;
                        r_cnt   <= CNT_INIT;
                        r_state <= ROOT;
                    end
                    // Always R iterations, even for small sums, so latency never depends on data.
                    ROOT: begin
                        if (w_ge) begin
                            r_num <= r_num - w_trial;
                            r_res <= (r_res >> 1) + r_bit;
                        end else begin
                            r_res <= r_res >> 1;
                        end
                        r_bit <= r_bit >> 2;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1))
                            r_state <= RND;
                    end
                    RND: begin
                        r_rem       <= r_num[Q-1:0];
                        r_mag       <= (r_round && (r_num > r_res)) ? r_res[R-1:0] + R'(1)
                                                                     : r_res[R-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                    OUT: if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vec_magnitude_core.sv
// Self-checking bench for vec_magnitude_core at W=8 (directed) and W=4/W=12 (random sweep).
module tb_vec_magnitude_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena, clr, out_ready;
    logic [15:0] xi [3];
    logic [15:0] yi [3];
    logic [15:0] zi [3];
    logic vi [3];
    logic m3i [3];
    logic rndi [3];
    logic rdy [3];
    logic ov [3];
    logic bsy [3];
    logic [16:0] mag [3];
    logic [17:0] rem [3];
    logic [8:0]  mag8;
    logic [9:0]  rem8;
    logic [4:0]  mag4;
    logic [5:0]  rem4;
    logic [12:0] mag12;
    logic [13:0] rem12;
    int widths [3] = '{8, 4, 12};

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    vec_magnitude_core #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(vi[0]), .in_ready(rdy[0]),
        .in_x(xi[0][7:0]), .in_y(yi[0][7:0]), .in_z(zi[0][7:0]),
        .in_mode3d(m3i[0]), .in_round(rndi[0]),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_mag(mag8), .out_rem(rem8), .busy(bsy[0]));

    vec_magnitude_core #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(vi[1]), .in_ready(rdy[1]),
        .in_x(xi[1][3:0]), .in_y(yi[1][3:0]), .in_z(zi[1][3:0]),
        .in_mode3d(m3i[1]), .in_round(rndi[1]),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_mag(mag4), .out_rem(rem4), .busy(bsy[1]));

    vec_magnitude_core #(.W(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(vi[2]), .in_ready(rdy[2]),
        .in_x(xi[2][11:0]), .in_y(yi[2][11:0]), .in_z(zi[2][11:0]),
        .in_mode3d(m3i[2]), .in_round(rndi[2]),
        .out_valid(ov[2]), .out_ready(out_ready),
        .out_mag(mag12), .out_rem(rem12), .busy(bsy[2]));

    assign mag[0] = 17'(mag8);
    assign rem[0] = 18'(rem8);
    assign mag[1] = 17'(mag4);
    assign rem[1] = 18'(rem4);
    assign mag[2] = 17'(mag12);
    assign rem[2] = 18'(rem12);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint isqrt(input longint s);
        longint r;
        r = longint'($sqrt(real'(s)));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Reference: exact integer floor root; rounding picks the integer nearest the real root.
    task automatic check_model(input string tag, input longint x, y, z, input logic m, r,
                               input logic [16:0] gm, input logic [17:0] gr);
        longint sum, root, em;
        sum  = x*x + y*y + (m ? z*z : 0);
        root = isqrt(sum);
        em   = (r && (4*sum > (2*root + 1) * (2*root + 1))) ? root + 1 : root;
        chk({tag, "_mag"}, 64'(gm), 64'(em));
        chk({tag, "_rem"}, 64'(gr), 64'(sum - root*root));
    endtask

    task automatic run_op(input int s, input logic [15:0] x, y, z, input logic m, r,
                          input int dis, input int hold,
                          output int en_e, output int all_e,
                          output logic [16:0] gm, output logic [17:0] gr);
        bit done = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(rdy[s]), 64'd1);
        xi[s] = x; yi[s] = y; zi[s] = z; m3i[s] = m; rndi[s] = r; vi[s] = 1'b1;
        @(posedge clk);
        #1 vi[s] = 1'b0;
        chk("busy_after_accept", 64'(bsy[s]), 64'd1);
        en_e = 0;
        all_e = 0;
        while (all_e < 300) begin
            @(negedge clk);
            if (dis > 0 && !done && en_e == 5) begin
                ena = 1'b0;
                repeat (dis) begin
                    @(posedge clk);
                    all_e++;
                end
                @(negedge clk);
                ena = 1'b1;
                done = 1'b1;
            end
            @(posedge clk);
            all_e++;
            en_e++;
            #1;
            if (ov[s]) break;
        end
        chk("out_valid_timeout", 64'(ov[s]), 64'd1);
        gm = mag[s];
        gr = rem[s];
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(ov[s]), 64'd1);
            chk("hold_mag", 64'(mag[s]), 64'(gm));
            chk("hold_rem", 64'(rem[s]), 64'(gr));
            chk("hold_in_ready", 64'(rdy[s]), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("valid_dropped", 64'(ov[s]), 64'd0);
        chk("ready_back", 64'(rdy[s]), 64'd1);
        chk("mag_kept", 64'(mag[s]), 64'(gm));
    endtask

    initial begin
        int en_e, all_e, cyc;
        logic [16:0] gm;
        logic [17:0] gr;
        logic [15:0] rx, ry, rz;
        logic rm, rr;

        rst_n = 1'b0; ena = 1'b1; clr = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xi[i] = '0; yi[i] = '0; zi[i] = '0; vi[i] = 1'b0; m3i[i] = 1'b0; rndi[i] = 1'b0;
        end
        #12;
        chk("rst_in_ready", 64'(rdy[0]), 64'd1);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_busy", 64'(bsy[0]), 64'd0);
        chk("rst_mag", 64'(mag[0]), 64'd0);
        chk("rst_rem", 64'(rem[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 3, 4, 0, 0, 0, 0, 0, en_e, all_e, gm, gr);
        chk("lat_3_4", 64'(en_e), 64'd12);
        chk("mag_3_4", 64'(gm), 64'd5);
        chk("rem_3_4", 64'(gr), 64'd0);

        run_op(0, 255, 255, 0, 0, 0, 0, 0, en_e, all_e, gm, gr);
        chk("mag_255_2d_floor", 64'(gm), 64'd360);
        chk("rem_255_2d_floor", 64'(gr), 64'd450);
        run_op(0, 255, 255, 0, 0, 1, 0, 0, en_e, all_e, gm, gr);
        chk("mag_255_2d_round", 64'(gm), 64'd361);
        chk("rem_255_2d_round", 64'(gr), 64'd450);

        run_op(0, 255, 255, 255, 1, 0, 0, 0, en_e, all_e, gm, gr);
        chk("mag_255_3d_floor", 64'(gm), 64'd441);
        chk("rem_255_3d_floor", 64'(gr), 64'd594);
        run_op(0, 255, 255, 255, 1, 1, 0, 0, en_e, all_e, gm, gr);
        chk("mag_255_3d_round", 64'(gm), 64'd442);
        run_op(0, 0, 0, 0, 1, 1, 0, 0, en_e, all_e, gm, gr);
        chk("mag_zero", 64'(gm), 64'd0);
        chk("rem_zero", 64'(gr), 64'd0);

        run_op(0, 2, 3, 0, 0, 1, 0, 0, en_e, all_e, gm, gr);
        chk("mag_2_3_round", 64'(gm), 64'd4);
        chk("rem_2_3_round", 64'(gr), 64'd4);
        run_op(0, 1, 2, 2, 0, 1, 0, 0, en_e, all_e, gm, gr);
        chk("mag_z_ignored", 64'(gm), 64'd2);
        chk("rem_z_ignored", 64'(gr), 64'd1);

        run_op(0, 100, 77, 0, 0, 0, 0, 20, en_e, all_e, gm, gr);
        check_model("backpressure", 100, 77, 0, 0, 0, gm, gr);

        run_op(0, 12, 34, 56, 1, 1, 7, 0, en_e, all_e, gm, gr);
        chk("ena_gap_enabled_edges", 64'(en_e), 64'd12);
        chk("ena_gap_all_edges", 64'(all_e), 64'd19);
        check_model("ena_gap", 12, 34, 56, 1, 1, gm, gr);

        // Abort mid-ROOT: must return to IDLE and never present a result.
        @(negedge clk);
        xi[0] = 200; yi[0] = 150; zi[0] = 0; m3i[0] = 0; rndi[0] = 0; vi[0] = 1'b1;
        @(posedge clk);
        #1 vi[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk("clr_in_ready", 64'(rdy[0]), 64'd1);
        chk("clr_busy", 64'(bsy[0]), 64'd0);
        chk("clr_out_valid", 64'(ov[0]), 64'd0);
        cyc = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (ov[0]) cyc++;
        end
        chk("clr_no_partial", 64'(cyc), 64'd0);

        // Reset pulse while holding a result in OUT; pending in_valid must not be taken meanwhile.
        @(negedge clk);
        xi[0] = 9; yi[0] = 40; zi[0] = 0; m3i[0] = 0; rndi[0] = 0; vi[0] = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        while (!ov[0] && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("out_wait_timeout", 64'(ov[0]), 64'd1);
        chk("mag_9_40", 64'(mag[0]), 64'd41);
        repeat (3) @(posedge clk);
        #1;
        chk("pending_not_taken", 64'(rdy[0]), 64'd0);
        chk("pending_valid_held", 64'(ov[0]), 64'd1);
        @(negedge clk);
        vi[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(ov[0]), 64'd0);
        chk("arst_mag", 64'(mag[0]), 64'd0);
        chk("arst_rem", 64'(rem[0]), 64'd0);
        chk("arst_in_ready", 64'(rdy[0]), 64'd1);
        chk("arst_busy", 64'(bsy[0]), 64'd0);
        #2 rst_n = 1'b1;

        for (int s = 1; s < 3; s++) begin
            run_op(s, 16'((1 << widths[s]) - 1), 16'((1 << widths[s]) - 1),
                   16'((1 << widths[s]) - 1), 1, 1, 0, 1, en_e, all_e, gm, gr);
            check_model("max_3d", (1 << widths[s]) - 1, (1 << widths[s]) - 1,
                        (1 << widths[s]) - 1, 1, 1, gm, gr);
            for (int n = 0; n < 30; n++) begin
                rx = 16'($urandom_range(0, (1 << widths[s]) - 1));
                ry = 16'($urandom_range(0, (1 << widths[s]) - 1));
                rz = 16'($urandom_range(0, (1 << widths[s]) - 1));
                rm = 1'($urandom_range(0, 1));
                rr = 1'($urandom_range(0, 1));
                run_op(s, rx, ry, rz, rm, rr, (n % 5 == 0) ? 3 : 0,
                       int'($urandom_range(0, 2)), en_e, all_e, gm, gr);
                chk("rand_latency", 64'(en_e), 64'(widths[s] + 4));
                check_model("rand", rx, ry, rz, rm, rr, gm, gr);
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/vec_magnitude_core.md
# vec_magnitude_core

Parametrised Euclidean-magnitude engine that computes round(sqrt(x²+y²)) or round(sqrt(x²+y²+z²)) for unsigned W-bit operands. It uses a restoring, bit-serial integer square root with fixed latency. Operands enter over a valid/ready input handshake, and the result leaves over a valid/ready output handshake. The block sits between the tile input pins and the output register bank, and replaces the earlier fixed 8-bit, 2-D, free-running magnitude FSM.

## Interface
- W, default 8: operand width in bits, range 4..16. Derived widths: S = 2W+2 (sum), R = W+1 (root), Q = W+2 (remainder).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  global clock enable. While low, all state and outputs freeze.
- clr  in  1  synchronous abort, qualified by ena. Returns the FSM to IDLE and drops out_valid.
- in_valid  in  1  operand set valid.
- in_ready  out  1  high only in IDLE.
- in_x, in_y, in_z  in  W each  unsigned operands. in_z is ignored when in_mode3d=0.
- in_mode3d  in  1  1 selects 3-D magnitude; captured with the operands.
- in_round  in  1  1 selects round-to-nearest, 0 selects floor; captured with the operands.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts.
- out_mag  out  R  magnitude.
- out_rem  out  Q  floor remainder, equal to sum − floor_root². Always the floor remainder, independent of rounding.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SQR, SUM, ROOT, RND, OUT. A rising edge counts only when ena=1.
- IDLE: in_ready=1. On in_valid, capture x/y/z (z forced to 0 when in_mode3d=0), mode3d and round; go to SQR.
- SQR: register x², y², z², each 2W bits. Go to SUM.
- SUM: sum = x²+y²+z², zero-extended to S bits. Initialise num=sum, res=0, b=1<<(S−2), iteration counter=R. Go to ROOT.
- ROOT: run exactly R iterations with no leading-bit skip, so latency is data-independent. Each iteration:
  - if num ≥ res+b: num −= res+b; res = (res>>1)+b.
  - else: res >>= 1.
  - b >>= 2.
  - After iteration R, go to RND.
- RND: out_rem = num[Q−1:0]. If round=1 and num > res, out_mag = res+1; otherwise out_mag = res. Set out_valid=1 and go to OUT.
  - res+1 never overflows R bits for any W.
  - An exact .5 case cannot occur for integer inputs.
- OUT: hold out_mag, out_rem and out_valid. On out_ready, clear out_valid and go to IDLE.
- Simultaneous events:
  - clr has priority over every other event in every state.
  - An in_valid that arrives while not in IDLE is not accepted; it stays pending with the source.
- Reset and abort mid-operation:
  - rst_n assertion aborts any state immediately (asynchronous).
  - clr aborts at the next enabled edge.
  - A partial result is never presented.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_mag=0, out_rem=0, state=IDLE.
- Acceptance edge is T0, where in_valid and in_ready are both high.
- out_valid rises after edge T0+R+3 (W=8: T0+12). Latency counts enabled edges only.
- in_ready returns high the cycle after the out_ready handshake. No back-to-back overlap: throughput is one result per R+4 enabled cycles plus the output wait.
- out_mag and out_rem are stable for the whole time out_valid=1. They keep their last value after acceptance until the next RND.

## Test plan
- W=8, 2-D, floor, (3,4) -> out_mag=5, out_rem=0; out_valid exactly 12 enabled edges after acceptance.
- W=8, 2-D, (255,255): floor -> 360, rem=450; round -> 361.
- W=8, 3-D, (255,255,255): floor -> 441, rem=594; round -> 442. Also (0,0,0) -> 0, rem=0.
- W=8, 2-D, round, (2,3) -> 4, rem=4. Then 3-D (1,2,2) with z ignored test: mode3d=0 -> 2, rem=1.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid, out_mag and out_rem stable, in_ready=0. Toggle ena low mid-ROOT -> latency extends by exactly the number of disabled cycles.
- Abort: clr in ROOT -> next cycle IDLE with out_valid=0. rst_n pulse in OUT -> all outputs at reset values. Random sweep at W=4 and W=12 against a reference sqrt model.
